// File: rtl/mac_sched.sv
// mac_sched: walks num image/weight pairs through the mac1 datapath and streams each sum out over valid/ready.
// Optional running-argmax tracking is compiled in with `define MAC_SCHED_ARGMAX_EN.
module mac_sched #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [127:0]      mem_p,
  input  logic [127:0]      mem_w,
  output logic [127:0]      mac_p,
  output logic [127:0]      mac_w,
  input  logic [19:0]       mac_s,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [19:0]       res_data,
  output logic [ADDR_W-1:0] res_idx,
  output logic              busy,
  output logic              done,
  output logic [19:0]       max_s,
  output logic [ADDR_W-1:0] max_idx
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, CAPT, OUT, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] num_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_inc;
  logic              hs;
  logic              run_go;

  assign idx_inc = idx + 1'b1;
  assign hs      = res_valid && res_ready;
  assign run_go  = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (num != '0) ? FETCH : DONE;
      end
      FETCH: begin
        mem_rd    = 1'b1;
        mem_addr  = idx;
        state_nxt = LOAD;
      end
      LOAD: state_nxt = CAPT;
      CAPT: state_nxt = OUT;
      OUT: begin
        if (hs) state_nxt = (idx_inc == num_q) ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q     <= '0;
      idx       <= '0;
      mac_p     <= '0;
      mac_w     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      if (run_go) begin
        num_q <= num;
        idx   <= '0;
      end
      if (state == LOAD) begin
        mac_p <= mem_p;
        mac_w <= mem_w;
      end
      // mac_s is combinational from mac_p, so it is settled by the end of CAPT
      if (state == CAPT) begin
        res_data  <= mac_s;
        res_idx   <= idx;
        res_valid <= 1'b1;
      end
      if (state == OUT && hs) begin
        res_valid <= 1'b0;
        idx       <= idx_inc;
      end
    end
  end

`ifdef MAC_SCHED_ARGMAX_EN
  logic [19:0]       max_q;
  logic [ADDR_W-1:0] max_idx_q;

  // strict compare keeps the lower index on ties; index 0 always seeds the max
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q     <= '0;
      max_idx_q <= '0;
    end else if (run_go) begin
      max_q     <= '0;
      max_idx_q <= '0;
    end else if (state == CAPT && (mac_s > max_q || idx == '0)) begin
      max_q     <= mac_s;
      max_idx_q <= idx;
    end
  end

  assign max_s   = max_q;
  assign max_idx = max_idx_q;
`else
  assign max_s   = '0;
  assign max_idx = '0;
`endif

endmodule
